xnor_gate: RTL and testbench
============================

// Module: xnor_gate
// PURPOSE
// - Bitwise XNOR (equality) cell: combinational y = ~(a ^ b), plus a registered stage
//   with a valid flag, an all-bits-equal flag and a count of matching bits.
// - Used as a leaf comparator in datapath match/compare logic.
// - WIDTH=1 default gives a drop-in 2-input XNOR gate on a/b/y.
// PARAMETERS
// - WIDTH   1    operand width in bits (>=1)
// - CNT_W   $clog2(WIDTH+1)   width of match_cnt (derived localparam, not overridable)
// PORTS
// - clk        in   1       single clock, rising edge
// - rst_n      in   1       reset, asynchronous assert, active-low
// - a          in   WIDTH   operand A
// - b          in   WIDTH   operand B
// - in_valid   in   1       sample a/b into the register stage this cycle
// - y          out  WIDTH   combinational ~(a ^ b); no clock involvement
// - out_valid  out  1       registered: y_q/all_eq/match_cnt hold a fresh result
// - y_q        out  WIDTH   registered ~(a ^ b) of the last accepted sample
// - all_eq     out  1       registered: 1 when a == b (all y bits 1)
// - match_cnt  out  CNT_W   registered number of 1 bits in ~(a ^ b)
// - mismatch_cnt out 16     registered count of accepted samples with a != b (see CONFIGURATION)
// BEHAVIOUR
// - One clock (clk); reset asynchronous and active-low (rst_n); deassert synchronised externally.
// - y: pure combinational, valid within the delta/propagation of a/b changes; independent of
//   clk, rst_n, in_valid; X/Z on an input bit yields X on that y bit only.
// - Truth per bit: 00->1, 01->0, 10->0, 11->1.
// - Reset (rst_n=0): out_valid=0, y_q=0, all_eq=0, match_cnt=0, mismatch_cnt=0, immediately.
// - Latency 1 cycle: on rising clk with in_valid=1, y_q<=~(a^b), all_eq<=(a==b),
//   match_cnt<=popcount(~(a^b)), out_valid<=1.
// - in_valid=0 at a clk edge: out_valid<=0; y_q/all_eq/match_cnt hold previous values.
// - No backpressure: every in_valid=1 cycle is accepted; back-to-back samples allowed.
// - match_cnt range 0..WIDTH; WIDTH=1 -> match_cnt equals y_q.
// - Reset mid-stream: pending sample discarded, all registers return to reset values.
// - in_valid unconnected/X is not supported; tie to 1'b1 or 1'b0 when only y is used.
// CONFIGURATION
// - Macro XNOR_GATE_STATS_EN.
// - Defined: mismatch_cnt increments by 1 on each accepted sample with a != b; saturates at
//   16'hFFFF (no wrap); cleared only by rst_n.
// - Not defined: mismatch_cnt tied to 16'h0000; no counter flops synthesised; port kept.
// STRUCTURE
// - Package xnor_gate_pkg: function cnt_w(width) = $clog2(width+1) (min 1); constant
//   STATS_W=16; constant STATS_MAX=16'hFFFF.
// - Sub-module xnor_popcount #(WIDTH): combinational popcount of a WIDTH vector -> CNT_W;
//   instantiated once on ~(a^b).
// - Top: combinational y, one register stage, optional stats counter under the macro.
// TESTING
// - WIDTH=1, rst_n=1: apply (a,b)=00,01,10,11 each held 1 ns -> y=1,0,0,1 after 1 ns.
// - rst_n=0 asynchronous mid-cycle -> out_valid=0,y_q=0,all_eq=0,match_cnt=0 without clk edge.
// - WIDTH=8, in_valid=1, a=8'hA5,b=8'hA5 -> next edge y_q=8'hFF,all_eq=1,match_cnt=8.
// - WIDTH=8, a=8'hF0,b=8'h0F then in_valid=0 -> y_q=8'h00,all_eq=0,match_cnt=0,out_valid=1;
//   next edge out_valid=0, data held.
// - WIDTH=8, a=8'h01,b=8'h00 -> match_cnt=7,all_eq=0; with XNOR_GATE_STATS_EN mismatch_cnt=1.
// - XNOR_GATE_STATS_EN, 65540 mismatching samples -> mismatch_cnt=16'hFFFF; without macro =0.

Source files
------------

// File: rtl/xnor_gate_pkg.sv
// Shared constants and width helper for the xnor_gate comparator cell.
// The optional mismatch statistics counter is enabled by the macro XNOR_GATE_STATS_EN.
package xnor_gate_pkg;

    localparam int STATS_W = 16;
    localparam logic [STATS_W-1:0] STATS_MAX = 16'hFFFF;

    // Width needed to hold a count in 0..width, never narrower than one bit.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module xnor_popcount
    import xnor_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] sum_s;

    // Ripple sum of the set bits.
    always_comb begin
        sum_s = {CNT_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            sum_s = sum_s + {{(CNT_W-1){1'b0}}, vec[i]};
        end
    end

    assign cnt = sum_s;

endmodule

// File: rtl/xnor_gate.sv
// Bitwise XNOR cell with a one-cycle registered result stage (match flags and count).
// Define XNOR_GATE_STATS_EN to build the saturating mismatch_cnt statistics counter.
module xnor_gate
    import xnor_gate_pkg::*;
#(
    parameter int WIDTH = 1,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   y,
    output logic               out_valid,
    output logic [WIDTH-1:0]   y_q,
    output logic               all_eq,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [STATS_W-1:0] mismatch_cnt
);

    logic [WIDTH-1:0] eq_s;
    logic [CNT_W-1:0] pop_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] y_q_r;
    logic             all_eq_r;
    logic [CNT_W-1:0] match_cnt_r;

    assign eq_s = ~(a ^ b);
    assign y    = eq_s;

    xnor_popcount #(.WIDTH(WIDTH)) u_popcount (
        .vec (eq_s),
        .cnt (pop_s)
    );

    // Result stage: captures on in_valid, otherwise holds data and drops valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            y_q_r       <= {WIDTH{1'b0}};
            all_eq_r    <= 1'b0;
            match_cnt_r <= {CNT_W{1'b0}};
        end else if (in_valid) begin
            out_valid_r <= 1'b1;
            y_q_r       <= eq_s;
            all_eq_r    <= &eq_s;
            match_cnt_r <= pop_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign y_q       = y_q_r;
    assign all_eq    = all_eq_r;
    assign match_cnt = match_cnt_r;

`ifdef XNOR_GATE_STATS_EN
    logic [STATS_W-1:0] mismatch_cnt_r;

    // Saturating count of accepted samples that differ; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt_r <= {STATS_W{1'b0}};
        end else if (in_valid && !(&eq_s) && (mismatch_cnt_r != STATS_MAX)) begin
            mismatch_cnt_r <= mismatch_cnt_r + 16'd1;
        end else begin
            mismatch_cnt_r <= mismatch_cnt_r;
        end
    end

    assign mismatch_cnt = mismatch_cnt_r;
`else
    assign mismatch_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_xnor_gate.sv
// Directed self-checking bench for xnor_gate at WIDTH=1 and WIDTH=8.
module tb_xnor_gate;

`ifdef XNOR_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;

    logic        a1, b1, iv1, y1, ov1, yq1, eq1, mc1;
    logic [15:0] mm1;

    logic [7:0]  a8, b8, y8, yq8;
    logic        iv8, ov8, eq8;
    logic [3:0]  mc8;
    logic [15:0] mm8;

    int checks = 0;
    int errors = 0;

    xnor_gate #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1), .y(y1),
        .out_valid(ov1), .y_q(yq1), .all_eq(eq1), .match_cnt(mc1), .mismatch_cnt(mm1)
    );

    xnor_gate #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8), .y(y8),
        .out_valid(ov8), .y_q(yq8), .all_eq(eq8), .match_cnt(mc8), .mismatch_cnt(mm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; iv8 = 1'b0;
        #3;
        chk("rst_out_valid", {31'd0, ov8}, 32'd0);
        chk("rst_y_q",       {24'd0, yq8}, 32'd0);
        chk("rst_all_eq",    {31'd0, eq8}, 32'd0);
        chk("rst_match_cnt", {28'd0, mc8}, 32'd0);
        chk("rst_mismatch",  {16'd0, mm8}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Combinational truth table, WIDTH=1
        a1 = 1'b0; b1 = 1'b0; #1; chk("y1_00", {31'd0, y1}, 32'd1);
        a1 = 1'b0; b1 = 1'b1; #1; chk("y1_01", {31'd0, y1}, 32'd0);
        a1 = 1'b1; b1 = 1'b0; #1; chk("y1_10", {31'd0, y1}, 32'd0);
        a1 = 1'b1; b1 = 1'b1; #1; chk("y1_11", {31'd0, y1}, 32'd1);
        a8 = 8'h3C; b8 = 8'h5A; #1; chk("y8_comb", {24'd0, y8}, 32'h0000_0099);

        // Equal operands
        tick();
        a8 = 8'hA5; b8 = 8'hA5; iv8 = 1'b1;
        tick();
        chk("a5_out_valid", {31'd0, ov8}, 32'd1);
        chk("a5_y_q",       {24'd0, yq8}, 32'h0000_00FF);
        chk("a5_all_eq",    {31'd0, eq8}, 32'd1);
        chk("a5_match_cnt", {28'd0, mc8}, 32'd8);
        chk("a5_mismatch",  {16'd0, mm8}, 32'd0);

        // Fully different operands, then idle cycle holds data
        a8 = 8'hF0; b8 = 8'h0F;
        tick();
        chk("f0_out_valid", {31'd0, ov8}, 32'd1);
        chk("f0_y_q",       {24'd0, yq8}, 32'h0000_0000);
        chk("f0_all_eq",    {31'd0, eq8}, 32'd0);
        chk("f0_match_cnt", {28'd0, mc8}, 32'd0);
        chk("f0_mismatch",  {16'd0, mm8}, STATS ? 32'd1 : 32'd0);
        iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        tick();
        chk("idle_out_valid", {31'd0, ov8}, 32'd0);
        chk("idle_y_q",       {24'd0, yq8}, 32'h0000_0000);
        chk("idle_match_cnt", {28'd0, mc8}, 32'd0);
        chk("idle_all_eq",    {31'd0, eq8}, 32'd0);
        chk("idle_mismatch",  {16'd0, mm8}, STATS ? 32'd1 : 32'd0);

        // Single-bit difference
        a8 = 8'h01; b8 = 8'h00; iv8 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        tick();
        chk("one_y_q",       {24'd0, yq8}, 32'h0000_00FE);
        chk("one_match_cnt", {28'd0, mc8}, 32'd7);
        chk("one_all_eq",    {31'd0, eq8}, 32'd0);
        chk("one_mismatch",  {16'd0, mm8}, STATS ? 32'd2 : 32'd0);
        chk("w1_y_q",        {31'd0, yq1}, 32'd1);
        chk("w1_match_cnt",  {31'd0, mc1}, 32'd1);
        chk("w1_all_eq",     {31'd0, eq1}, 32'd1);
        a1 = 1'b1; b1 = 1'b0;
        tick();
        chk("w1d_y_q",       {31'd0, yq1}, 32'd0);
        chk("w1d_match_cnt", {31'd0, mc1}, 32'd0);
        chk("w1d_mismatch",  {16'd0, mm1}, STATS ? 32'd1 : 32'd0);
        iv1 = 1'b0;

        // Asynchronous reset mid-cycle, no clock edge in between
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, ov8}, 32'd0);
        chk("arst_y_q",       {24'd0, yq8}, 32'd0);
        chk("arst_all_eq",    {31'd0, eq8}, 32'd0);
        chk("arst_match_cnt", {28'd0, mc8}, 32'd0);
        chk("arst_mismatch",  {16'd0, mm8}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Saturation of the mismatch counter
        a8 = 8'h01; b8 = 8'h00; iv8 = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre", {16'd0, mm8}, STATS ? 32'h0000_FFFE : 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("sat_final", {16'd0, mm8}, STATS ? 32'h0000_FFFF : 32'd0);
        iv8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
